// File: rtl/data_mem_responder.sv
// data_mem_responder: word-wide data memory answering processor loads/stores,
// with single-cycle writes and fixed-latency reads that raise busy while in flight.
module data_mem_responder #(
    parameter int D_BITS       = 32,
    parameter int A_BITS       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_i,
    input  logic              read_i,
    input  logic [A_BITS-1:0] address_i,
    input  logic [D_BITS-1:0] data_in_i,
    output logic [D_BITS-1:0] data_out_o,
    output logic              data_valid_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [D_BITS-1:0] mem [2**A_BITS];
    logic [D_BITS-1:0] snap;
    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              wr;
    logic              acc;

    // RESP is the final cycle of a read, so a read arriving there starts the next one
    always_comb begin
        wr  = write_i & ~read_i;
        acc = read_i & ~write_i & (state != WAIT);
    end

    assign busy_o = state != IDLE;

    always_ff @(posedge clk_i) begin
        if (wr) mem[address_i] <= data_in_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            snap         <= '0;
            data_out_o   <= '0;
            data_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            err_o        <= read_i & ~acc;
            if (acc) begin
                snap  <= mem[address_i];
                cnt   <= 4'(READ_LATENCY - 1);
                state <= WAIT;
            end else if (state == WAIT) begin
                if (cnt == 4'd0) begin
                    state        <= RESP;
                    data_valid_o <= 1'b1;
                    data_out_o   <= snap;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
endmodule
